// File: rtl/tinyalu_if.sv
// tinyalu_if: command/response bundle between a TinyALU initiator (master) and responder (slave).
interface tinyalu_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    modport master (output A, B, op, start, input done, result);
    modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_responder.sv
// tinyalu_responder: TinyALU command responder; define TINYALU_MUL_EN to build the multi-cycle multiplier,
// otherwise mul_op completes in one cycle with a zero result.
module tinyalu_responder #(
    parameter int MUL_LATENCY = 3
) (
    input logic       clk,
    input logic       reset,
    tinyalu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, REARM} state_t;
    state_t      r_state, w_state;
    logic [7:0]  r_a, r_b;
    logic [2:0]  r_op;
    logic        r_pend, w_pend;
    logic        r_done, w_done;
    logic [15:0] r_result, w_result, w_alu;
    logic        w_accept;
`ifdef TINYALU_MUL_EN
    logic [2:0]  r_cnt, w_cnt;
`endif

    if (MUL_LATENCY < 2 || MUL_LATENCY > 7) begin : g_bad_latency
        $error("MUL_LATENCY must be in 2..7");
    end

    always_comb begin
        w_alu = (r_op == 3'b001) ? {7'b0, {1'b0, r_a} + {1'b0, r_b}} :
                (r_op == 3'b010) ? {8'b0, r_a & r_b} :
                (r_op == 3'b011) ? {8'b0, r_a ^ r_b} :
`ifdef TINYALU_MUL_EN
                (r_op == 3'b100) ? {8'b0, r_a} * {8'b0, r_b} :
`endif
                16'h0000;
    end

    // Single-cycle ops complete in REARM on the edge after acceptance, tracked by r_pend.
    always_comb begin
        w_state  = r_state;
        w_pend   = 1'b0;
        w_done   = 1'b0;
        w_result = r_result;
        w_accept = 1'b0;
`ifdef TINYALU_MUL_EN
        w_cnt    = r_cnt;
`endif
        case (r_state)
            IDLE: if (bus.start) begin
                w_accept = 1'b1;
`ifdef TINYALU_MUL_EN
                w_pend   = bus.op inside {3'b001, 3'b010, 3'b011};
                w_cnt    = 3'(MUL_LATENCY - 1);
                w_state  = (bus.op == 3'b100) ? BUSY : REARM;
`else
                w_pend   = bus.op inside {3'b001, 3'b010, 3'b011, 3'b100};
                w_state  = REARM;
`endif
            end
            BUSY: begin
`ifdef TINYALU_MUL_EN
                w_done   = (r_cnt == 3'd0);
                w_result = w_done ? w_alu : r_result;
                w_cnt    = w_done ? r_cnt : r_cnt - 3'd1;
                w_state  = w_done ? REARM : BUSY;
`else
                w_state  = IDLE;
`endif
            end
            REARM: begin
                w_done   = r_pend;
                w_result = r_pend ? w_alu : r_result;
                w_state  = bus.start ? REARM : IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_op     <= 3'b000;
            r_pend   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 16'h0000;
`ifdef TINYALU_MUL_EN
            r_cnt    <= 3'd0;
`endif
        end else begin
            r_state  <= w_state;
            r_pend   <= w_pend;
            r_done   <= w_done;
            r_result <= w_result;
`ifdef TINYALU_MUL_EN
            r_cnt    <= w_cnt;
`endif
            if (w_accept) begin
                r_a  <= bus.A;
                r_b  <= bus.B;
                r_op <= bus.op;
            end
        end
    end

    assign bus.done   = r_done;
    assign bus.result = r_result;
endmodule

// File: tb/tb_tinyalu_responder.sv
// tb_tinyalu_responder: directed vectors; stimulus queues expected results, a negedge monitor checks each done.
module tb_tinyalu_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    typedef struct {
        logic [15:0] res;
        int          due;
    } exp_t;
    exp_t q[$];

    tinyalu_if bus();
    tinyalu_responder #(.MUL_LATENCY(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef TINYALU_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: result %h with no command pending (cycle %0d)", bus.result, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_result", {16'h0, bus.result}, {16'h0, e.res});
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    // Enters and leaves at #1 after a rising edge; hold = extra cycles start stays high after done.
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat, input bit has_done, input int hold);
        int k;
        bus.A = a;
        bus.B = b;
        bus.op = o;
        bus.start = 1'b1;
        if (has_done) q.push_back('{exp, cyc + 1 + lat});
        @(posedge clk); #1;
        bus.A = 8'h00;
        bus.B = 8'h00;
        bus.op = 3'b000;
        if (has_done) begin
            k = 0;
            while (bus.done !== 1'b1 && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            if (bus.done !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            @(posedge clk); #1;
        end else begin
            bus.start = 1'b0;
            repeat (10) begin
                @(posedge clk); #1;
            end
            chk("held_result", {16'h0, bus.result}, {16'h0, exp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.A = 8'h00;
        bus.B = 8'h00;
        bus.op = 3'b000;
        bus.start = 1'b0;
        #2;
        chk("reset_done", {31'h0, bus.done}, 32'd0);
        chk("reset_result", {16'h0, bus.result}, 32'h0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        issue(3'b001, 8'hFF, 8'h01, 16'h0100, 1, 1'b1, 0);
        issue(3'b000, 8'h12, 8'h34, 16'h0100, 0, 1'b0, 0);
        issue(3'b011, 8'hA5, 8'h5A, 16'h00FF, 1, 1'b1, 0);
        issue(3'b010, 8'hF0, 8'h3C, 16'h0030, 1, 1'b1, 0);
        issue(3'b111, 8'h01, 8'h01, 16'h0030, 0, 1'b0, 0);
        issue(3'b001, 8'hFF, 8'hFF, 16'h01FE, 1, 1'b1, 4);
        chk("result_hold", {16'h0, bus.result}, 32'h01FE);
`ifdef TINYALU_MUL_EN
        issue(3'b100, 8'hFF, 8'hFF, 16'hFE01, MUL_LAT, 1'b1, 0);
        issue(3'b100, 8'h10, 8'h11, 16'h0110, MUL_LAT, 1'b1, 2);
        // start withdrawn mid-multiply: the operation must still finish
        bus.A = 8'h07;
        bus.B = 8'h09;
        bus.op = 3'b100;
        bus.start = 1'b1;
        q.push_back('{16'h003F, cyc + 1 + MUL_LAT});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (MUL_LAT + 2) begin
            @(posedge clk); #1;
        end
        chk("drop_start_result", {16'h0, bus.result}, 32'h003F);
`else
        issue(3'b100, 8'h03, 8'h04, 16'h0000, MUL_LAT, 1'b1, 0);
`endif
        issue(3'b001, 8'h80, 8'h01, 16'h0081, 1, 1'b1, 0);

        // reset between acceptance and completion aborts the command
        bus.A = 8'h02;
        bus.B = 8'h03;
        bus.op = 3'b100;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_done", {31'h0, bus.done}, 32'd0);
        chk("abort_result", {16'h0, bus.result}, 32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("abort_quiet", {16'h0, bus.result}, 32'h0);

        issue(3'b011, 8'h0F, 8'h0F, 16'h0000, 1, 1'b1, 0);
        issue(3'b001, 8'h01, 8'h02, 16'h0003, 1, 1'b1, 0);
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/tinyalu_responder.md
TINYALU_RESPONDER -- requirements
Module: tinyalu_responder

Interface
REQ-001 Parameter MUL_LATENCY, default 3, is the number of clock edges from command acceptance to done for mul_op; legal range 2..7.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 op  input  3  opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op, 101/110/111 reserved.
REQ-007 start  input  1  command request from the initiator, held high until done is seen.
REQ-008 done  output  1  one-cycle completion pulse, registered.
REQ-009 result  output  16  operation result, registered.

Function
REQ-010 FSM states: IDLE, BUSY, REARM.
REQ-011 In IDLE, a rising edge with start=1 accepts the command and captures A, B and op into internal registers.
REQ-012 Captured operands are used for the whole operation; A/B/op changes after acceptance shall not affect the result.
REQ-013 add_op: result = {7'b0, A+B} (9-bit carry kept); and_op: {8'b0, A&B}; xor_op: {8'b0, A^B}; mul_op: full 16-bit unsigned A*B.
REQ-014 add/and/xor: result updated and done high on the first edge after acceptance; FSM goes IDLE->REARM.
REQ-015 mul_op: IDLE->BUSY; a down-counter loaded with MUL_LATENCY-1 decrements each edge; done and result update on edge MUL_LATENCY after acceptance; BUSY->REARM.
REQ-016 no_op and reserved opcodes: accepted, no done pulse, result unchanged; IDLE->REARM.
REQ-017 done is high for exactly one cycle per completed command, never for no_op/reserved.
REQ-018 REARM->IDLE on the first edge where start=1'b0; a command needs start low for at least one edge before the next acceptance.
REQ-019 start dropping during BUSY (protocol violation): operation still completes and done still pulses.
REQ-020 start held high after done: no second acceptance until start has been sampled low.
REQ-021 result holds its last value between completions.

Reset
REQ-022 reset asserted: FSM=IDLE, done=0, result=16'h0000, counter and captured operands cleared, immediately without waiting for clk.
REQ-023 reset mid-operation aborts the command; no done pulse follows for the aborted command.
REQ-024 First acceptance possible on the first rising edge after reset deasserts, if start=1.

Configuration
REQ-025 Macro TINYALU_MUL_EN defined: mul_op behaves per REQ-013/REQ-015.
REQ-026 Macro TINYALU_MUL_EN undefined: no multiplier or BUSY counter logic; mul_op completes like a single-cycle op with result=16'h0000 and done on the first edge after acceptance.

Verification
REQ-027 reset, then add_op A=8'hFF B=8'h01 -> done one edge after acceptance, result=16'h0100, done low next cycle.
REQ-028 xor_op A=8'hA5 B=8'h5A, then and_op A=8'hF0 B=8'h3C with one start-low cycle between -> results 16'h00FF then 16'h0030, one done each.
REQ-029 mul_op A=8'hFF B=8'hFF, A/B changed to 8'h00 after acceptance -> done exactly 3 edges after acceptance, result=16'hFE01.
REQ-030 no_op with start high one cycle, after a prior add result 16'h0100 -> no done pulse for 10 cycles, result stays 16'h0100.
REQ-031 mul_op accepted, reset pulsed one edge later -> done=0, result=16'h0000 immediately; no done within next 5 cycles.
REQ-032 TINYALU_MUL_EN undefined, mul_op A=8'h03 B=8'h04 -> done one edge after acceptance, result=16'h0000.
